tlul_host_mux_2to1: RTL and testbench

- Downstream of the core wrapper: merges the instruction and data TL-UL host ports into one TL-UL host port toward the crossbar.
- Arbitrates the A channel with round-robin and tags each request's a_source with the host index.
- Routes D-channel responses back by source tag and tracks per-host outstanding transactions.
- Stalls a host that reaches its outstanding limit.

---
 rtl/tlul_mux_pkg.sv | 62 ++++++
 rtl/tlul_outstanding_cnt.sv | 33 +++
 rtl/tlul_host_mux_2to1.sv | 112 +++++++++++
 tb/tb_tlul_host_mux_2to1.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_mux_pkg.sv
// Shared TL-UL types and source-tagging helpers for the 2:1 host mux.
// The host index lives in the LSB of the merged a_source/d_source.
package tlul_mux_pkg;

  localparam int TL_AW    = 32;
  localparam int TL_DW    = 32;
  localparam int TL_AIW   = 8;
  localparam int TL_DIW   = 1;
  localparam int TL_DBW   = TL_DW / 8;
  localparam int TL_SZW   = 2;
  localparam int HostIdxW = 1;

  typedef enum logic [HostIdxW-1:0] {
    HostInstr = 1'b0,
    HostData  = 1'b1
  } host_idx_e;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  function automatic logic [TL_AIW-1:0] tag_source(input logic [TL_AIW-1:0] src,
                                                   input host_idx_e         idx);
    return {src[TL_AIW-2:0], idx};
  endfunction

  function automatic logic [TL_AIW-1:0] untag_source(input logic [TL_AIW-1:0] src);
    return {1'b0, src[TL_AIW-1:1]};
  endfunction

endpackage

// File: rtl/tlul_outstanding_cnt.sv
// Per-host in-flight counter: saturating up/down with full/empty status.
// Underflow flags a decrement that arrives while the counter is empty.
module tlul_outstanding_cnt #(
  parameter int unsigned MaxCount = 2,
  parameter int unsigned CntW     = $clog2(MaxCount + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o,
  output logic underflow_o
);

  logic [CntW-1:0] cnt_q;

  assign full_o      = (cnt_q == CntW'(MaxCount));
  assign empty_o     = (cnt_q == '0);
  assign underflow_o = dec_i & empty_o;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && !dec_i && !full_o) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (dec_i && !inc_i && !empty_o) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/tlul_host_mux_2to1.sv
// Merges instruction and data TL-UL hosts onto one port: round-robin A arbitration
// with source tagging, D routing by tag, and per-host outstanding limits.
module tlul_host_mux_2to1
  import tlul_mux_pkg::*;
#(
  parameter  int unsigned MaxOutstanding = 2,
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_h0_i,
  output tl_d2h_t tl_h0_o,
  input  tl_h2d_t tl_h1_i,
  output tl_d2h_t tl_h1_o,
  output tl_h2d_t tl_o,
  input  tl_d2h_t tl_i,
  output logic    spurious_rsp_o,
  output logic    busy_o
);

  tl_h2d_t    h_req [2];
  tl_d2h_t    h_rsp [2];
  logic [1:0] elig, full, empty, underflow, inc, dec, gnt_oh, d_oh;
  host_idx_e  gnt, didx, rr_ptr, locked_idx;
  logic       lock, a_valid, a_hs, d_ready, d_hs;

  assign h_req[0] = tl_h0_i;
  assign h_req[1] = tl_h1_i;
  assign elig     = {h_req[1].a_valid & ~full[1], h_req[0].a_valid & ~full[0]};

  // A stalled beat keeps its grant so the presented A fields never change mid-stall.
  always_comb begin
    if (lock) begin
      gnt = locked_idx;
    end else if (&elig) begin
      gnt = rr_ptr;
    end else if (elig[1]) begin
      gnt = HostData;
    end else begin
      gnt = HostInstr;
    end
  end

  assign a_valid = elig[gnt] & ~rst_i;
  assign a_hs    = a_valid & tl_i.a_ready;
  assign didx    = host_idx_e'(tl_i.d_source[0]);
  assign d_ready = h_req[didx].d_ready & ~rst_i;
  assign d_hs    = tl_i.d_valid & d_ready;
  assign gnt_oh  = {gnt == HostData, gnt == HostInstr};
  assign d_oh    = {didx == HostData, didx == HostInstr};
  assign inc     = gnt_oh & {2{a_hs}};
  assign dec     = d_oh & {2{d_hs}};

  // NOTE: each always_comb assigns its full output first, so no path leaves a value held (no latch).
  always_comb begin
    tl_o          = h_req[gnt];
    tl_o.a_valid  = a_valid;
    tl_o.a_source = tag_source(h_req[gnt].a_source, gnt);
    tl_o.d_ready  = d_ready;
  end

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      h_rsp[n]          = tl_i;
      h_rsp[n].d_source = untag_source(tl_i.d_source);
      h_rsp[n].d_valid  = tl_i.d_valid & d_oh[n] & ~rst_i;
      h_rsp[n].a_ready  = tl_i.a_ready & gnt_oh[n] & ~full[n] & ~rst_i;
    end
  end

  assign tl_h0_o = h_rsp[0];
  assign tl_h1_o = h_rsp[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= HostInstr;
      lock       <= 1'b0;
      locked_idx <= HostInstr;
    end else if (a_hs) begin
      lock   <= 1'b0;
      rr_ptr <= host_idx_e'(~gnt);
    end else if (a_valid) begin
      lock       <= 1'b1;
      locked_idx <= gnt;
    end
  end

  for (genvar n = 0; n < 2; n++) begin : gen_cnt
    tlul_outstanding_cnt #(
      .MaxCount(MaxOutstanding),
      .CntW    (CntW)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_i      (inc[n]),
      .dec_i      (dec[n]),
      .full_o     (full[n]),
      .empty_o    (empty[n]),
      .underflow_o(underflow[n])
    );
  end

  assign spurious_rsp_o = |underflow & ~rst_i;
  assign busy_o         = ~&empty & ~rst_i;

  // The top tag bit is consumed by the host index; a host must leave it clear.
  a_src_msb_h0: assert property (@(posedge clk_i) disable iff (rst_i)
                                 tl_h0_i.a_valid |-> !tl_h0_i.a_source[TL_AIW-1]);
  a_src_msb_h1: assert property (@(posedge clk_i) disable iff (rst_i)
                                 tl_h1_i.a_valid |-> !tl_h1_i.a_source[TL_AIW-1]);

endmodule

// File: tb/tb_tlul_host_mux_2to1.sv
// Directed scenarios plus a randomized phase, all cross-checked every cycle
// against a transaction-level model of the 2:1 host mux.
module tb_tlul_host_mux_2to1;
  import tlul_mux_pkg::*;

  localparam int MAX = 2;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  tl_h2d_t hreq [2];
  tl_d2h_t hrsp [2];
  tl_h2d_t tl_o;
  tl_d2h_t xbar;
  logic    spurious_rsp_o, busy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: outstanding per host, preferred host on a tie, host held by a stall (-1 none).
  int out [2];
  int pref  = 0;
  int stall = -1;
  // Per-cycle predictions carried from the sample point to the clock edge.
  bit m_av, m_dhs;
  int m_g, m_d;

  logic [TL_AIW-1:0] rsp_q [$];

  always #5 clk = ~clk;

  tlul_host_mux_2to1 #(.MaxOutstanding(MAX)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tl_h0_i       (hreq[0]),
    .tl_h0_o       (hrsp[0]),
    .tl_h1_i       (hreq[1]),
    .tl_h1_o       (hrsp[1]),
    .tl_o          (tl_o),
    .tl_i          (xbar),
    .spurious_rsp_o(spurious_rsp_o),
    .busy_o        (busy_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Settle after the input change, predict this cycle from the model and compare.
  task automatic settle_check();
    bit e [2];
    int g, d;
    #1;
    for (int h = 0; h < 2; h++) e[h] = hreq[h].a_valid && (out[h] < MAX);
    if (stall >= 0)      g = stall;
    else if (e[0] && e[1]) g = pref;
    else if (e[1])       g = 1;
    else                 g = 0;
    m_g  = g;
    m_av = !rst && e[g];
    check("a_valid", tl_o.a_valid, m_av);
    if (m_av) begin
      check("a_source", tl_o.a_source, hreq[g].a_source * 2 + g);
      check("a_address", tl_o.a_address, hreq[g].a_address);
      check("a_data", tl_o.a_data, hreq[g].a_data);
    end
    for (int h = 0; h < 2; h++)
      check($sformatf("h%0d_a_ready", h), hrsp[h].a_ready,
            !rst && g == h && out[h] < MAX && xbar.a_ready);
    d     = xbar.d_source % 2;
    m_d   = d;
    m_dhs = !rst && xbar.d_valid && hreq[d].d_ready;
    check("d_ready", tl_o.d_ready, !rst && hreq[d].d_ready);
    for (int h = 0; h < 2; h++)
      check($sformatf("h%0d_d_valid", h), hrsp[h].d_valid, !rst && xbar.d_valid && d == h);
    if (!rst && xbar.d_valid) begin
      check("d_source", hrsp[d].d_source, xbar.d_source / 2);
      check("d_data", hrsp[d].d_data, xbar.d_data);
    end
    check("spurious", spurious_rsp_o, m_dhs && out[d] == 0);
    check("busy", busy_o, !rst && (out[0] + out[1]) > 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      out   = '{0, 0};
      pref  = 0;
      stall = -1;
    end else begin
      if (m_av && xbar.a_ready) begin
        out[m_g]++;
        pref  = 1 - m_g;
        stall = -1;
      end else if (m_av) begin
        stall = m_g;
      end
      if (m_dhs && out[m_d] > 0) out[m_d]--;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_a(input int h, input bit v, input logic [7:0] src, input logic [31:0] addr);
    hreq[h].a_valid   = v;
    hreq[h].a_source  = src;
    hreq[h].a_address = addr;
    hreq[h].a_data    = addr ^ 32'h5a5a_0000;
    hreq[h].a_opcode  = Get;
  endtask

  task automatic d_beat(input logic [7:0] src);
    xbar.d_valid  = 1'b1;
    xbar.d_source = src;
    xbar.d_data   = 32'hd000_0000 | src;
    settle_check();
    tick();
    xbar.d_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int g, prev;
    logic [7:0] tag;
    bit hs [2];
    bit dh;
    out     = '{0, 0};
    hreq[0] = '0;
    hreq[1] = '0;
    xbar    = '0;
    @(negedge clk);

    // Reset: every valid/ready output low, then counters idle.
    set_a(0, 1, 8'd1, 32'h10);
    xbar.a_ready = 1'b1;
    xbar.d_valid = 1'b1;
    repeat (2) begin settle_check(); tick(); end
    rst = 1'b0;
    set_a(0, 0, 0, 0);
    xbar.d_valid    = 1'b0;
    hreq[0].d_ready = 1'b1;
    hreq[1].d_ready = 1'b1;

    // Contention: both hosts always requesting, responses one cycle later.
    set_a(0, 1, 8'd5, 32'h100);
    set_a(1, 1, 8'd9, 32'h200);
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      settle_check();
      g = int'(tl_o.a_source[0]);
      check("rr_grant", g, i % 2);
      if (prev >= 0) check("rr_alternate", g != prev, 1);
      prev = g;
      tag  = tl_o.a_source;
      tick();
      xbar.d_valid  = 1'b1;
      xbar.d_source = tag;
    end
    set_a(0, 0, 0, 0);
    set_a(1, 0, 0, 0);
    settle_check();
    tick();
    xbar.d_valid = 1'b0;

    // Single host0 read with source tagging and response untagging.
    set_a(0, 1, 8'd3, 32'h1000);
    settle_check();
    check("t1_a_source", tl_o.a_source, 8'h06);
    tick();
    set_a(0, 0, 0, 0);
    xbar.d_valid  = 1'b1;
    xbar.d_source = 8'h06;
    settle_check();
    check("t1_d_source", hrsp[0].d_source, 8'h03);
    check("t1_busy_on", busy_o, 1);
    tick();
    xbar.d_valid = 1'b0;
    settle_check();
    check("t1_busy_off", busy_o, 0);
    tick();

    // Backpressure lock: h1 stalled three cycles, h0 arrives mid-stall.
    xbar.a_ready = 1'b0;
    set_a(1, 1, 8'h11, 32'h2000);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) set_a(0, 1, 8'h02, 32'h1004);
      settle_check();
      check("lock_src", tl_o.a_source, 8'h23);
      check("lock_addr", tl_o.a_address, 32'h2000);
      tick();
    end
    xbar.a_ready = 1'b1;
    settle_check();
    check("lock_hs", hrsp[1].a_ready, 1);
    tick();
    set_a(1, 0, 0, 0);
    settle_check();
    check("after_lock_src", tl_o.a_source, 8'h04);
    tick();
    set_a(0, 0, 0, 0);
    d_beat(8'h23);
    d_beat(8'h04);

    // Outstanding limit: third write from h1 waits for a response.
    for (int i = 0; i < 2; i++) begin
      set_a(1, 1, 8'h21, 32'h3000 + 4 * i);
      hreq[1].a_opcode = PutFullData;
      settle_check();
      check("lim_accept", hrsp[1].a_ready, 1);
      tick();
    end
    set_a(1, 1, 8'h21, 32'h3008);
    hreq[1].a_opcode = PutFullData;
    for (int i = 0; i < 2; i++) begin
      settle_check();
      check("lim_held_ready", hrsp[1].a_ready, 0);
      check("lim_held_valid", tl_o.a_valid, 0);
      tick();
    end
    xbar.d_valid  = 1'b1;
    xbar.d_source = 8'h43;
    settle_check();
    check("lim_same_cycle", hrsp[1].a_ready, 0);
    tick();
    xbar.d_valid = 1'b0;
    settle_check();
    check("lim_release", hrsp[1].a_ready, 1);
    check("lim_release_addr", tl_o.a_address, 32'h3008);
    tick();
    set_a(1, 0, 0, 0);
    d_beat(8'h43);
    d_beat(8'h43);

    // Simultaneous A and D handshakes on h0, then a spurious h1 response.
    set_a(0, 1, 8'd1, 32'h40);
    settle_check();
    tick();
    set_a(0, 1, 8'd2, 32'h44);
    xbar.d_valid  = 1'b1;
    xbar.d_source = 8'h02;
    settle_check();
    check("sim_no_spur", spurious_rsp_o, 0);
    tick();
    set_a(0, 0, 0, 0);
    xbar.d_source = 8'h04;
    settle_check();
    check("sim_cnt_one", spurious_rsp_o, 0);
    tick();
    xbar.d_valid = 1'b0;
    settle_check();
    check("sim_busy_off", busy_o, 0);
    tick();
    xbar.d_valid  = 1'b1;
    xbar.d_source = 8'h0f;
    settle_check();
    check("spur_pulse", spurious_rsp_o, 1);
    check("spur_fwd", hrsp[1].d_valid, 1);
    tick();
    xbar.d_valid = 1'b0;
    settle_check();
    check("spur_done", spurious_rsp_o, 0);
    tick();

    // Reset mid-operation with cnt0 full and h1 locked.
    for (int i = 0; i < 2; i++) begin
      set_a(0, 1, 8'd3, 32'h4000 + 4 * i);
      settle_check();
      tick();
    end
    set_a(0, 0, 0, 0);
    set_a(1, 1, 8'h0a, 32'h5000);
    xbar.a_ready = 1'b0;
    settle_check();
    check("pre_rst_lock", tl_o.a_source, 8'h15);
    tick();
    rst = 1'b1;
    settle_check();
    check("rst_a_valid", tl_o.a_valid, 0);
    check("rst_busy", busy_o, 0);
    tick();
    rst          = 1'b0;
    xbar.a_ready = 1'b1;
    settle_check();
    check("post_rst_grant", tl_o.a_source, 8'h15);
    check("post_rst_ready", hrsp[1].a_ready, 1);
    check("post_rst_busy", busy_o, 0);
    tick();
    set_a(1, 0, 0, 0);
    xbar.d_valid  = 1'b1;
    xbar.d_source = 8'h06;
    settle_check();
    check("stale_spur", spurious_rsp_o, 1);
    tick();
    d_beat(8'h15);

    // Randomized traffic with an in-order crossbar responder.
    for (int i = 0; i < 700; i++) begin
      settle_check();
      for (int h = 0; h < 2; h++) hs[h] = hreq[h].a_valid && hrsp[h].a_ready;
      if (tl_o.a_valid && xbar.a_ready) rsp_q.push_back(tl_o.a_source);
      dh = xbar.d_valid && tl_o.d_ready;
      tick();
      for (int h = 0; h < 2; h++) begin
        if (hs[h]) hreq[h].a_valid = 1'b0;
        if (!hreq[h].a_valid && i < 580 && $urandom_range(1) == 1)
          set_a(h, 1, 8'($urandom_range(127)), $urandom);
        if (hreq[h].a_valid && hs[h] == 0 && $urandom_range(1) == 1)
          hreq[h].a_opcode = hreq[h].a_opcode;
        hreq[h].d_ready = ($urandom_range(3) != 0);
      end
      xbar.a_ready = ($urandom_range(9) < 7);
      if (dh) xbar.d_valid = 1'b0;
      if (!xbar.d_valid && rsp_q.size() > 0 && $urandom_range(9) < 4) begin
        xbar.d_valid  = 1'b1;
        xbar.d_source = rsp_q.pop_front();
        xbar.d_data   = $urandom;
      end
    end
    check("drained", rsp_q.size() + int'(xbar.d_valid) + int'(hreq[0].a_valid)
                     + int'(hreq[1].a_valid), 0);
    settle_check();
    check("final_busy", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
